pmem_line_responder: RTL and testbench

PMEM_LINE_RESPONDER -- requirements
Module: pmem_line_responder

---
 rtl/lc3b_types.sv | 11 +
 rtl/line_word_ram.sv | 33 +++
 rtl/pmem_line_responder.sv | 145 ++++++++++++++
 tb/tb_pmem_line_responder.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lc3b_types.sv
// Shared LC-3b type definitions used by the memory-side blocks.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_mem_data;
    typedef logic [3:0]   lc3b_c_offset;
    typedef logic [2:0]   lc3b_pmem_beat;

    localparam int unsigned PMEM_BEATS = 8;

endpackage

// File: rtl/line_word_ram.sv
// Single-port 16-bit word RAM: synchronous read, write-first on the same address.
module line_word_ram
    import lc3b_types::*;
#(
    parameter int unsigned Depth = 512,
    parameter int unsigned AddrW = 9
) (
    input  logic             clk_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] addr_i,
    input  lc3b_word         wdata_i,
    output lc3b_word         rdata_o
);

    lc3b_word mem_q [Depth];
    lc3b_word rdata_q;

    // No reset and no init: unwritten words read back as X in simulation.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                mem_q[addr_i] <= wdata_i;
                rdata_q       <= wdata_i;
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pmem_line_responder.sv
// Physical-memory model: serves 128-bit line reads/writes after a fixed latency,
// moving the line as eight 16-bit beats through a single-port word RAM.
module pmem_line_responder
    import lc3b_types::*;
#(
    parameter int unsigned LATENCY = 4,
    parameter int unsigned LINES   = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pmem_read,
    input  logic         pmem_write,
    input  lc3b_word     pmem_address,
    input  lc3b_mem_data pmem_wdata,
    output lc3b_mem_data pmem_rdata,
    output logic         pmem_resp,
    output logic         proto_err
);

    localparam int unsigned IdxW = $clog2(LINES);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StWait = 2'd1;
    localparam logic [1:0] StXfer = 2'd2;
    localparam logic [1:0] StDone = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [3:0]      wait_cnt_q, wait_cnt_d;
    logic [3:0]      beat_q, beat_d;
    logic            is_write_q, is_write_d;
    logic [IdxW-1:0] idx_q, idx_d;
    lc3b_mem_data    wdata_q, wdata_d;
    lc3b_mem_data    rdata_q;
    logic            err_q, err_d;

    logic            req;
    logic            ram_en;
    logic            ram_we;
    lc3b_word        ram_wdata;
    lc3b_word        ram_rdata;
    logic            capture;
    lc3b_pmem_beat   cap_beat;
    logic            unused_addr;

    assign req         = pmem_read | pmem_write;
    // Offset bits and aliased upper bits are intentionally ignored.
    assign unused_addr = ^pmem_address;

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        beat_d     = beat_q;
        is_write_d = is_write_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        err_d      = err_q;
        case (state_q)
            StIdle: begin
                if (req) begin
                    is_write_d = pmem_write;
                    idx_d      = pmem_address[4 +: IdxW];
                    wdata_d    = pmem_wdata;
                    wait_cnt_d = 4'(LATENCY - 1);
                    err_d      = err_q | (pmem_read & pmem_write);
                    state_d    = StWait;
                end
            end
            StWait: begin
                if (wait_cnt_q == 4'd0) begin
                    beat_d  = 4'd0;
                    state_d = StXfer;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            StXfer: begin
                // Beat 8 only drains the last synchronous read.
                if (beat_q == 4'(PMEM_BEATS)) begin
                    beat_d  = 4'd0;
                    state_d = StDone;
                end else begin
                    beat_d = beat_q + 4'd1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if ((state_q == StWait || state_q == StXfer) && !req) begin
            err_d = 1'b1;
        end
    end

    assign ram_en    = (state_q == StXfer) && !beat_q[3];
    assign ram_we    = ram_en && is_write_q;
    assign ram_wdata = wdata_q[{beat_q[2:0], 4'b0000} +: 16];

    // Word issued on beat N lands in the RAM output register one cycle later.
    assign capture  = (state_q == StXfer) && (beat_q != 4'd0) && !is_write_q;
    assign cap_beat = lc3b_pmem_beat'(beat_q - 4'd1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wait_cnt_q <= 4'd0;
            beat_q     <= 4'd0;
            is_write_q <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            beat_q     <= beat_d;
            is_write_q <= is_write_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            err_q      <= err_d;
            if (capture) begin
                rdata_q[{cap_beat, 4'b0000} +: 16] <= ram_rdata;
            end
        end
    end

    line_word_ram #(
        .Depth (LINES * PMEM_BEATS),
        .AddrW (IdxW + 3)
    ) u_ram (
        .clk_i   (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  ({idx_q, beat_q[2:0]}),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    assign pmem_rdata = rdata_q;
    assign pmem_resp  = (state_q == StDone);
    assign proto_err  = err_q;

endmodule

// File: tb/tb_pmem_line_responder.sv
// Self-checking bench for pmem_line_responder (LATENCY=4, LINES=64).
module tb_pmem_line_responder;

    localparam int Lat = 4;
    localparam int RespEdge = Lat + 10;

    logic         clk;
    logic         rst;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;
    logic         proto_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [127:0] mem_model [64];
    logic [127:0] exp_q [$];
    logic [127:0] last_rdata;

    pmem_line_responder #(
        .LATENCY (Lat),
        .LINES   (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .proto_err    (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drives one request and reports the edge (counted from the sampling edge)
    // at which pmem_resp is seen high; lat = -1 if it never comes.
    task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                           input logic [127:0] wd, input int drop_after,
                           output int lat, output logic [127:0] rdata_seen,
                           output logic err_seen);
        int start;
        @(negedge clk);
        pmem_read    = rd;
        pmem_write   = wr;
        pmem_address = addr;
        pmem_wdata   = wd;
        start        = cyc + 1;
        lat          = -1;
        err_seen     = 1'b0;
        rdata_seen   = 'x;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 0) err_seen = proto_err;
            if (drop_after > 0 && i + 1 == drop_after) begin
                pmem_read  = 1'b0;
                pmem_write = 1'b0;
            end
            if (pmem_resp) begin
                lat        = cyc - start + 1;
                rdata_seen = pmem_rdata;
                break;
            end
        end
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst        = 1'b1;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        last_rdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (pmem_resp !== 1'b0) begin
            errors++;
            $display("FAIL reset_resp: got %b expected 0", pmem_resp);
        end
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: got %b expected 0", proto_err);
        end
        checks++;
        if (pmem_rdata !== 128'h0) begin
            errors++;
            $display("FAIL reset_rdata: got %h expected 0", pmem_rdata);
        end
        rst        = 1'b0;
        last_rdata = '0;
    endtask

    task automatic test_write_read();
        int           lat;
        logic [127:0] rd;
        logic         e;
        logic [127:0] v = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        run_txn(1'b0, 1'b1, 16'h0040, v, 0, lat, rd, e);
        mem_model[4] = v;
        checks++;
        if (lat !== RespEdge) begin
            errors++;
            $display("FAIL wr_latency: got %0d expected %0d", lat, RespEdge);
        end
        checks++;
        if (rd !== last_rdata) begin
            errors++;
            $display("FAIL wr_keeps_rdata: got %h expected %h", rd, last_rdata);
        end
        exp_q.push_back(mem_model[4'hA >> 1 == 5 ? 4 : 4]);
        run_txn(1'b1, 1'b0, 16'h004A, 128'h0, 0, lat, rd, e);
        checks++;
        if (lat !== RespEdge) begin
            errors++;
            $display("FAIL rd_latency: got %0d expected %0d", lat, RespEdge);
        end
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL rd_after_wr: got %h expected %h", rd, v);
        end
        last_rdata = rd;
        checks++;
        if (proto_err !== 1'b0) begin
            errors++;
            $display("FAIL clean_err: got %b expected 0", proto_err);
        end
    endtask

    task automatic test_alias();
        int           lat;
        logic [127:0] rd;
        logic         e;
        logic [127:0] pa = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        logic [127:0] pb = 128'hDEAD_BEEF_CAFE_F00D_0BAD_F00D_1234_ABCD;
        logic [15:0]  a1 = 16'h0010;
        logic [15:0]  a2 = 16'h0410;
        run_txn(1'b0, 1'b1, a1, pa, 0, lat, rd, e);
        mem_model[a1[9:4]] = pa;
        run_txn(1'b0, 1'b1, a2, pb, 0, lat, rd, e);
        mem_model[a2[9:4]] = pb;
        exp_q.push_back(mem_model[a1[9:4]]);
        run_txn(1'b1, 1'b0, a1, 128'h0, 0, lat, rd, e);
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL alias_data: got %h expected %h", rd, pb);
        end
        last_rdata = rd;
    endtask

    task automatic test_both_asserted();
        int           lat;
        logic [127:0] rd;
        logic         e;
        logic [127:0] ones = '1;
        run_txn(1'b1, 1'b1, 16'h0020, ones, 0, lat, rd, e);
        mem_model[2] = ones;
        checks++;
        if (e !== 1'b1) begin
            errors++;
            $display("FAIL both_err: got %b expected 1", e);
        end
        checks++;
        if (rd !== last_rdata) begin
            errors++;
            $display("FAIL both_is_write: got %h expected %h", rd, last_rdata);
        end
        apply_reset();
        exp_q.push_back(mem_model[2]);
        run_txn(1'b1, 1'b0, 16'h0020, 128'h0, 0, lat, rd, e);
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL both_readback: got %h expected all ones", rd);
        end
        last_rdata = rd;
    endtask

    task automatic test_reset_mid_write();
        int           lat;
        int           start;
        int           resp_seen = 0;
        logic [127:0] rd;
        logic         e;
        run_txn(1'b0, 1'b1, 16'h0030, 128'h0, 0, lat, rd, e);
        @(negedge clk);
        pmem_write   = 1'b1;
        pmem_address = 16'h0030;
        pmem_wdata   = {8{16'hAAAA}};
        start        = cyc + 1;
        // Cycle after edge Lat+3 is XFER beat 3.
        while (cyc < start + Lat + 3) begin
            @(negedge clk);
            if (pmem_resp) resp_seen++;
        end
        rst        = 1'b1;
        pmem_write = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (pmem_resp) resp_seen++;
        end
        checks++;
        if (resp_seen !== 0) begin
            errors++;
            $display("FAIL abort_no_resp: got %0d pulses expected 0", resp_seen);
        end
        mem_model[3] = 128'h0000_0000_0000_0000_AAAA_AAAA_AAAA_AAAA;
        exp_q.push_back(mem_model[3]);
        run_txn(1'b1, 1'b0, 16'h0030, 128'h0, 0, lat, rd, e);
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL abort_partial: got %h expected %h", rd, mem_model[3]);
        end
        last_rdata = rd;
    endtask

    task automatic test_back_to_back();
        int           lat;
        int           start;
        int           prev = -1;
        int           pulses = 0;
        int           unstable = 0;
        logic [127:0] rd;
        logic [127:0] held;
        logic         e;
        logic [127:0] v = 128'h5A5A_0F0F_F0F0_A5A5_1357_9BDF_2468_ACE0;
        run_txn(1'b0, 1'b1, 16'h0000, v, 0, lat, rd, e);
        mem_model[0] = v;
        for (int k = 0; k < 4; k++) exp_q.push_back(mem_model[0]);
        @(negedge clk);
        pmem_read    = 1'b1;
        pmem_address = 16'h0000;
        start        = cyc + 1;
        held         = 'x;
        for (int i = 0; i < 120 && pulses < 4; i++) begin
            @(negedge clk);
            if (pmem_resp) begin
                checks++;
                if (pmem_rdata !== exp_q.pop_front()) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h expected %h", pulses, pmem_rdata, v);
                end
                checks++;
                if (prev < 0) begin
                    if (cyc - start + 1 !== RespEdge) begin
                        errors++;
                        $display("FAIL b2b_first: got %0d expected %0d",
                                 cyc - start + 1, RespEdge);
                    end
                end else if (cyc - prev !== Lat + 11) begin
                    errors++;
                    $display("FAIL b2b_gap%0d: got %0d expected %0d", pulses, cyc - prev, Lat + 11);
                end
                prev = cyc;
                held = pmem_rdata;
                pulses++;
            end else if (pulses > 0 && pmem_rdata !== held) begin
                unstable++;
            end
        end
        pmem_read = 1'b0;
        checks++;
        if (pulses !== 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d expected 4", pulses);
        end
        checks++;
        if (unstable !== 0) begin
            errors++;
            $display("FAIL b2b_stable: got %0d changes expected 0", unstable);
        end
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_scoreboard: got %0d left expected 0", exp_q.size());
        end
        last_rdata = v;
    endtask

    task automatic test_early_drop();
        int           lat;
        logic [127:0] rd;
        logic         e;
        exp_q.push_back(mem_model[4]);
        run_txn(1'b1, 1'b0, 16'h0040, 128'h0, 2, lat, rd, e);
        checks++;
        if (lat !== RespEdge) begin
            errors++;
            $display("FAIL drop_latency: got %0d expected %0d", lat, RespEdge);
        end
        checks++;
        if (rd !== exp_q.pop_front()) begin
            errors++;
            $display("FAIL drop_data: got %h expected %h", rd, mem_model[4]);
        end
        checks++;
        if (proto_err !== 1'b1) begin
            errors++;
            $display("FAIL drop_err: got %b expected 1", proto_err);
        end
    endtask

    initial begin
        rst          = 1'b1;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 16'h0;
        pmem_wdata   = 128'h0;
        last_rdata   = '0;
        test_reset();
        test_write_read();
        test_alias();
        test_both_asserted();
        test_reset_mid_write();
        test_back_to_back();
        test_early_drop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
